// File: rtl/vga_sync_decoder_if.sv
// VGA receive bundle: sync/colour inputs from the controller
// and the capture RAM write port plus lock status.
interface vga_sync_decoder_if;
  logic        iHSync;
  logic        iVSync;
  logic        iRed;
  logic        iGreen;
  logic        iBlue;
  logic [15:0] oWriteAddress;
  logic [2:0]  oWriteData;
  logic        oWriteEnable;
  logic        oLocked;
  logic        oHSyncError;
  logic        oVSyncError;
  logic [7:0]  oFrameCount;

  modport master (
    output iHSync, iVSync, iRed, iGreen, iBlue,
    input  oWriteAddress, oWriteData, oWriteEnable,
    input  oLocked, oHSyncError, oVSyncError, oFrameCount
  );

  modport slave (
    input  iHSync, iVSync, iRed, iGreen, iBlue,
    output oWriteAddress, oWriteData, oWriteEnable,
    output oLocked, oHSyncError, oVSyncError, oFrameCount
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: recovers pixel/line position, checks sync timing,
// locks onto the frame and writes the centred window to capture RAM.
module vga_sync_decoder #(
  parameter int H_SYNC         = 96,
  parameter int H_BP           = 48,
  parameter int H_ACTIVE       = 640,
  parameter int H_TOTAL        = 800,
  parameter int V_SYNC         = 2,
  parameter int V_BP           = 29,
  parameter int V_TOTAL        = 521,
  parameter int CLKS_PER_PIXEL = 2,
  parameter int SAMPLE_PHASE   = 1,
  parameter int WIN_X0         = 192,
  parameter int WIN_Y0         = 112,
  parameter int WIN_W          = 256,
  parameter int WIN_H          = 256
) (
  input logic Clock,
  input logic Reset,
  vga_sync_decoder_if.slave vga
);

  localparam int PW =
    (CLKS_PER_PIXEL > 1) ? $clog2(CLKS_PER_PIXEL) : 1;

  localparam logic [PW-1:0] PH_LAST =
    PW'(CLKS_PER_PIXEL - 1);
  localparam logic [PW-1:0] PH_SMP = PW'(SAMPLE_PHASE);

  localparam logic [11:0] HS_CLKS =
    12'(H_SYNC * CLKS_PER_PIXEL);
  localparam logic [11:0] HT_CLKS =
    12'(H_TOTAL * CLKS_PER_PIXEL);
  localparam logic [9:0] VS_L = 10'(V_SYNC);
  localparam logic [9:0] VT_L = 10'(V_TOTAL);

  localparam logic [9:0]  X_OFF = 10'(H_SYNC + H_BP);
  localparam logic [9:0]  Y_OFF = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  WX0   = 10'(WIN_X0);
  localparam logic [9:0]  WY0   = 10'(WIN_Y0);
  localparam logic [10:0] WX1   = 11'(WIN_X0 + WIN_W);
  localparam logic [10:0] WY1   = 11'(WIN_Y0 + WIN_H);
  localparam logic [10:0] XA    = 11'(H_ACTIVE);

  typedef enum logic [1:0] {
    UNLOCKED,
    TRAIN,
    LOCKED
  } state_t;

  state_t state;

  logic          hs_q, vs_q, hs_p, vs_p;
  logic [2:0]    rgb_q;
  logic [PW-1:0] phase;
  logic [9:0]    hcount;
  logic [10:0]   hclk;
  logic [9:0]    vcount;
  logic          h_armed;

  logic        we_q, lock_q, herr_q, verr_q;
  logic [15:0] addr_q;
  logic [2:0]  data_q;
  logic [7:0]  fc_q;

  logic          hs_fall, hs_rise, vs_fall, vs_rise;
  logic [PW-1:0] ph_cur;
  logic          ph_wrap;
  logic [9:0]    hc_cur, vc_inc;
  logic [11:0]   hclk_nx;
  logic          h_err, v_err, err;
  logic [9:0]    x, y;
  logic          x_in, y_in, cap;
  logic [7:0]    xa, ya;

  assign hs_fall = hs_p & ~hs_q;
  assign hs_rise = ~hs_p & hs_q;
  assign vs_fall = vs_p & ~vs_q;
  assign vs_rise = ~vs_p & vs_q;

  // The fall cycle itself is pixel 0, phase 0 of the new line.
  assign ph_cur  = hs_fall ? '0 : phase;
  assign hc_cur  = hs_fall ? '0 : hcount;
  assign ph_wrap = (ph_cur == PH_LAST);
  assign vc_inc  = vcount + {9'd0, hs_fall};
  assign hclk_nx = {1'b0, hclk} + 12'd1;

  assign h_err =
    (hs_rise && hclk_nx != HS_CLKS) ||
    (hs_fall && h_armed && hclk_nx != HT_CLKS);
  assign v_err =
    (vs_rise && vc_inc != VS_L) ||
    (vs_fall && state != UNLOCKED &&
     vc_inc != VT_L);
  assign err = h_err | v_err;

  assign x    = hc_cur - X_OFF;
  assign y    = vcount - Y_OFF;
  assign x_in = (x >= WX0) && ({1'b0, x} < WX1) &&
                ({1'b0, x} < XA);
  assign y_in = (y >= WY0) && ({1'b0, y} < WY1);
  assign xa   = 8'(x - WX0);
  assign ya   = 8'(y - WY0);
  assign cap  = (state == LOCKED) && (ph_cur == PH_SMP) &&
                x_in && y_in && !err;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      hs_p   <= 1'b1;
      vs_p   <= 1'b1;
      rgb_q  <= '0;
      phase  <= '0;
      hcount <= '0;
      hclk   <= '0;
      vcount <= '0;
    end else begin
      hs_q   <= vga.iHSync;
      vs_q   <= vga.iVSync;
      hs_p   <= hs_q;
      vs_p   <= vs_q;
      rgb_q  <= {vga.iRed, vga.iGreen, vga.iBlue};
      phase  <= ph_wrap ? '0 : ph_cur + PW'(1);
      hcount <= hc_cur + {9'd0, ph_wrap};
      hclk   <= hs_fall ? '0 :
                (&hclk ? hclk : hclk + 11'd1);
      vcount <= vs_fall ? '0 : vc_inc;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state   <= UNLOCKED;
      h_armed <= 1'b0;
      lock_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      herr_q  <= 1'b0;
      verr_q  <= 1'b0;
      fc_q    <= '0;
    end else begin
      herr_q <= h_err;
      verr_q <= v_err;
      we_q   <= cap;
      if (cap) begin
        addr_q <= {ya, xa};
        data_q <= rgb_q;
      end
      if (hs_fall) h_armed <= 1'b1;
      unique case (state)
        UNLOCKED: begin
          if (vs_fall) state <= TRAIN;
        end
        TRAIN: begin
          if (err) begin
            state   <= UNLOCKED;
            h_armed <= 1'b0;
          end else if (vs_fall) begin
            state  <= LOCKED;
            lock_q <= 1'b1;
            fc_q   <= fc_q + 8'd1;
          end
        end
        LOCKED: begin
          if (err) begin
            state   <= UNLOCKED;
            lock_q  <= 1'b0;
            h_armed <= 1'b0;
          end else if (vs_fall) begin
            fc_q <= fc_q + 8'd1;
          end
        end
        default: begin
          state  <= UNLOCKED;
          lock_q <= 1'b0;
        end
      endcase
    end
  end

  assign vga.oWriteEnable  = we_q;
  assign vga.oWriteAddress = addr_q;
  assign vga.oWriteData    = data_q;
  assign vga.oLocked       = lock_q;
  assign vga.oHSyncError   = herr_q;
  assign vga.oVSyncError   = verr_q;
  assign vga.oFrameCount   = fc_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a scaled-down raster with a
// frame-level lock model and a per-write colour scoreboard.
module tb_vga_sync_decoder;

  localparam int H_SYNC = 6;
  localparam int H_BP   = 4;
  localparam int H_ACT  = 24;
  localparam int H_TOT  = 40;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 3;
  localparam int V_TOT  = 24;
  localparam int CPP    = 2;
  localparam int SPH    = 1;
  localparam int WX0    = 3;
  localparam int WY0    = 2;
  localparam int WW     = 16;
  localparam int WH     = 12;
  localparam int XS     = H_SYNC + H_BP;
  localparam int YS     = V_SYNC + V_BP;

  localparam int UNL = 0;
  localparam int TRN = 1;
  localparam int LCK = 2;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  vga_sync_decoder_if vif();

  vga_sync_decoder #(
    .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACT),
    .H_TOTAL(H_TOT), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .V_TOTAL(V_TOT), .CLKS_PER_PIXEL(CPP),
    .SAMPLE_PHASE(SPH), .WIN_X0(WX0), .WIN_Y0(WY0),
    .WIN_W(WW), .WIN_H(WH)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .vga(vif)
  );

  always #5 Clock = ~Clock;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input longint act,
                     input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  int ca, cb, cs;

  function automatic logic [2:0] colour(input int x, input int y);
    return 3'((x * ca + y * cb + cs) & 7);
  endfunction

  int wr_idx, fr_wr, fr_herr, fr_verr;
  logic        s_lock, e_lock;
  logic [7:0]  s_fc;
  logic [15:0] e_addr;

  always @(negedge Clock) begin
    if (Reset) begin
      if (vif.oHSyncError) fr_herr++;
      if (vif.oVSyncError) fr_verr++;
      if (vif.oWriteEnable) begin
        chk("wr_addr", vif.oWriteAddress,
            {8'(wr_idx / WW), 8'(wr_idx % WW)});
        chk("wr_data", vif.oWriteData,
            colour(wr_idx % WW + WX0, wr_idx / WW + WY0));
        wr_idx++;
        fr_wr++;
      end
    end
  end

  task automatic reset_checks(input string nm);
    chk({nm, "_we"},   vif.oWriteEnable, 0);
    chk({nm, "_lock"}, vif.oLocked, 0);
    chk({nm, "_fc"},   vif.oFrameCount, 0);
    chk({nm, "_addr"}, vif.oWriteAddress, 0);
    chk({nm, "_data"}, vif.oWriteData, 0);
    chk({nm, "_herr"}, vif.oHSyncError, 0);
    chk({nm, "_verr"}, vif.oVSyncError, 0);
  endtask

  task automatic send_frame(input int nl, input int vsl,
                            input int bad_ln, input int bad_w,
                            input int rst_ln, input int rst_px);
    int hw;
    wr_idx = 0; fr_wr = 0; fr_herr = 0; fr_verr = 0;
    for (int ln = 0; ln < nl; ln++) begin
      hw = (ln == bad_ln) ? bad_w : H_SYNC;
      for (int px = 0; px < H_TOT; px++) begin
        for (int c = 0; c < CPP; c++) begin
          @(negedge Clock);
          if (ln == 1 && px == 0 && c == 0) begin
            s_lock = vif.oLocked;
            s_fc   = vif.oFrameCount;
          end
          if (ln == nl - 1 && px == H_TOT - 1 && c == CPP - 1) begin
            e_lock = vif.oLocked;
            e_addr = vif.oWriteAddress;
          end
          if (ln == rst_ln && c == 0 && px == rst_px) begin
            Reset = 1'b0;
            #1;
            reset_checks("async_rst");
            wr_idx = 0; fr_wr = 0; fr_herr = 0; fr_verr = 0;
          end
          if (ln == rst_ln && c == 0 && px == rst_px + 3)
            Reset = 1'b1;
          vif.iHSync = (px >= hw);
          vif.iVSync = (ln >= vsl);
          {vif.iRed, vif.iGreen, vif.iBlue} =
            (px >= XS && ln >= YS) ? colour(px - XS, ln - YS) : 3'd0;
        end
      end
    end
  endtask

  int m_state, m_fc, prev_nl;

  task automatic run_frame(input string nm, input int nl,
                           input int vsl, input int bad_ln,
                           input int bad_w, input int rst_ln,
                           input int rst_px);
    int ev, eh, ew, es_lock, es_fc;
    ev = 0; eh = 0;
    if (m_state == UNL) begin
      m_state = TRN;
    end else if (prev_nl != V_TOT) begin
      ev++;
      m_state = UNL;
    end else begin
      if (m_state == TRN) m_state = LCK;
      m_fc = (m_fc + 1) % 256;
    end
    es_lock = (m_state == LCK) ? 1 : 0;
    es_fc   = m_fc;
    if (vsl != V_SYNC) begin ev++; m_state = UNL; end
    if (bad_ln >= 0)   begin eh++; m_state = UNL; end
    ew = (m_state == LCK) ? WW * WH : 0;
    if (rst_ln >= 0) begin
      m_state = UNL; m_fc = 0; ew = 0; ev = 0; eh = 0;
    end
    send_frame(nl, vsl, bad_ln, bad_w, rst_ln, rst_px);
    prev_nl = nl;
    chk({nm, " start_lock"}, s_lock, es_lock);
    chk({nm, " start_fc"},   s_fc, es_fc);
    chk({nm, " writes"},     fr_wr, ew);
    chk({nm, " herr"},       fr_herr, eh);
    chk({nm, " verr"},       fr_verr, ev);
    chk({nm, " end_lock"},   e_lock, (m_state == LCK) ? 1 : 0);
    if (ew > 0)
      chk({nm, " addr_hold"}, e_addr,
          {8'(WH - 1), 8'(WW - 1)});
  endtask

  task automatic rand_colour();
    ca = int'($urandom_range(0, 7));
    cb = int'($urandom_range(0, 7));
    cs = int'($urandom_range(0, 7));
  endtask

  initial begin
    int bl, bw, rl, rp;
    vif.iHSync = 1'b1;
    vif.iVSync = 1'b1;
    vif.iRed   = 1'b0;
    vif.iGreen = 1'b0;
    vif.iBlue  = 1'b0;
    ca = 1; cb = 1; cs = 0;
    #2 Reset = 1'b0;
    repeat (3) @(negedge Clock);
    reset_checks("reset");
    Reset = 1'b1;
    repeat (4) @(negedge Clock);
    m_state = UNL; m_fc = 0; prev_nl = V_TOT;

    rand_colour();
    run_frame("nom1", V_TOT, V_SYNC, -1, 0, -1, 0);
    ca = 1; cb = 1; cs = 0;
    run_frame("nom2", V_TOT, V_SYNC, -1, 0, -1, 0);
    rand_colour();
    run_frame("nom3", V_TOT, V_SYNC, -1, 0, -1, 0);

    bl = int'($urandom_range(2, 6));
    bw = int'($urandom_range(1, H_SYNC - 1));
    rand_colour();
    run_frame("hs_short", V_TOT, V_SYNC, bl, bw, -1, 0);
    run_frame("hs_train", V_TOT, V_SYNC, -1, 0, -1, 0);
    rand_colour();
    run_frame("hs_relock", V_TOT, V_SYNC, -1, 0, -1, 0);

    rand_colour();
    run_frame("short_frm", V_TOT - 1, V_SYNC, -1, 0, -1, 0);
    run_frame("vt_err", V_TOT, V_SYNC, -1, 0, -1, 0);
    run_frame("vt_train", V_TOT, V_SYNC, -1, 0, -1, 0);
    rand_colour();
    run_frame("vt_relock", V_TOT, V_SYNC, -1, 0, -1, 0);

    rand_colour();
    run_frame("vs_long", V_TOT, V_SYNC + 1, -1, 0, -1, 0);
    run_frame("vs_train", V_TOT, V_SYNC, -1, 0, -1, 0);
    rand_colour();
    run_frame("vs_relock", V_TOT, V_SYNC, -1, 0, -1, 0);

    rl = int'($urandom_range(YS + WY0 + 1, YS + WY0 + WH - 2));
    rp = int'($urandom_range(XS + WX0 + 1, XS + WX0 + WW - 3));
    rand_colour();
    run_frame("mid_rst", V_TOT, V_SYNC, -1, 0, rl, rp);
    run_frame("rst_train", V_TOT, V_SYNC, -1, 0, -1, 0);
    rand_colour();
    run_frame("rst_relock", V_TOT, V_SYNC, -1, 0, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receiving end of the VGA output interface. Samples HSync, VSync and 3-bit RGB produced by the VGA controller.
- Recovers the pixel and line position, checks the sync timing, and locks onto the frame.
- While locked, writes the 256x256 centred window back into a 64K x 3 capture RAM through a write port.
- Used as a loopback checker and a frame grabber in the video subsystem.

Parameters:
- H_SYNC, 96, HSync low width in pixels
- H_BP, 48, horizontal back porch in pixels
- H_ACTIVE, 640, active pixels per line
- H_TOTAL, 800, pixels per line
- V_SYNC, 2, VSync low width in lines
- V_BP, 29, vertical back porch in lines
- V_TOTAL, 521, lines per frame
- CLKS_PER_PIXEL, 2, Clock cycles per pixel
- SAMPLE_PHASE, 1, pixel phase (0..CLKS_PER_PIXEL-1) at which RGB is sampled
- WIN_X0, 192, first captured active column
- WIN_Y0, 112, first captured active row

Ports:
- Clock  input  1  system clock
- Reset  input  1  asynchronous, active-low reset
- iHSync  input  1  horizontal sync, active low
- iVSync  input  1  vertical sync, active low
- iRed  input  1  red pixel bit
- iGreen  input  1  green pixel bit
- iBlue  input  1  blue pixel bit
- oWriteAddress  output  16  capture RAM address, {row[7:0], col[7:0]}
- oWriteData  output  3  {R,G,B}
- oWriteEnable  output  1  one-cycle write strobe
- oLocked  output  1  timing locked
- oHSyncError  output  1  one-cycle pulse on a horizontal timing violation
- oVSyncError  output  1  one-cycle pulse on a vertical timing violation
- oFrameCount  output  8  frames received while locked, wraps at 256

Behaviour:
- Reset low: all outputs 0, FSM in UNLOCKED, all counters 0, input registers set to sync=1 and RGB=0.
- Input registers: all inputs are registered once. Edges are detected against the previous registered value. All timing below is relative to the registered signals, so there is 1 cycle of input latency.
- Pixel phase counter (0..CLKS_PER_PIXEL-1):
  - Forced to 0 on an HSync falling edge; otherwise free-running and wrapping.
  - hcount (10 bits) increments when phase wraps. It is forced to 0 on an HSync falling edge.
- Clock-cycle counter hclk (11 bits, saturating):
  - Cleared on an HSync falling edge.
  - At the HSync rising edge: if hclk+1 != H_SYNC*CLKS_PER_PIXEL, pulse oHSyncError.
  - At an HSync falling edge: if hclk+1 != H_TOTAL*CLKS_PER_PIXEL, pulse oHSyncError. This check is skipped on the first HSync fall after reset or after entering UNLOCKED.
- Line counter vcount (10 bits):
  - Increments on each HSync falling edge.
  - Forced to 0 on a VSync falling edge. VSync wins over a simultaneous HSync fall.
- Vertical checks:
  - At the VSync rising edge: if vcount' != V_SYNC, pulse oVSyncError. vcount' is vcount including any same-cycle HSync-fall increment.
  - At a VSync falling edge: if vcount' != V_TOTAL, pulse oVSyncError. This check is skipped on the first VSync fall after UNLOCKED.
- FSM:
  - UNLOCKED: on a VSync fall, go to TRAIN.
  - TRAIN: any error goes to UNLOCKED. The next VSync fall with no error in the frame goes to LOCKED and sets oLocked=1.
  - LOCKED: any error goes to UNLOCKED and clears oLocked in the next cycle.
  - Error pulses are produced in every state, except for the skipped first-edge checks.
  - oFrameCount increments on each VSync fall that occurs in LOCKED, including the one entering LOCKED.
- Capture:
  - x = hcount-(H_SYNC+H_BP) and y = vcount-(V_SYNC+V_BP), both computed unsigned 10-bit.
  - When LOCKED, phase == SAMPLE_PHASE, WIN_X0 <= x < WIN_X0+256 and WIN_Y0 <= y < WIN_Y0+256: in the next cycle oWriteEnable=1, oWriteAddress={(y-WIN_Y0)[7:0],(x-WIN_X0)[7:0]}, oWriteData = registered {R,G,B}.
  - No writes occur outside the window or when not LOCKED.
  - oWriteAddress and oWriteData hold their last value when oWriteEnable=0.
- An error detected in the same cycle as a capture cancels that write.
- Reset assertion mid-frame returns immediately to the reset state. Resynchronisation requires a new VSync fall followed by one clean frame.

Test Plan:
- Nominal 800x521 timing at 2 clk/pixel, 3 frames -> oLocked=1 at the second VSync fall, oFrameCount=1 there and 2 at the third fall, no error pulses.
- Locked frame with pixel colour = (x+y)[2:0] -> exactly 65536 writes per frame. First write is addr 0x0000 with data (192+112)&7=0; last write is addr 0xFFFF with data (447+367)&7=6.
- HSync low width 95 pixels on one line while locked -> one oHSyncError pulse, oLocked falls, no writes until relock two VSync falls later.
- Frame of 520 lines -> oVSyncError at the VSync fall, FSM returns to UNLOCKED, oFrameCount holds.
- VSync low for 3 lines -> oVSyncError at the VSync rise, 0 writes in that frame.
- Reset asserted mid-window while writing -> oWriteEnable=0, oLocked=0, oFrameCount=0 asynchronously. Relock occurs after 2 further VSync falls.
